// File: rtl/seq_restoring_div_pkg.sv
// seq_restoring_div_pkg: shared FSM state type and default operand width for the restoring divider.
package seq_restoring_div_pkg;
   localparam int DEFAULT_WIDTH = 4;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/seq_restoring_div_if.sv
// seq_restoring_div_if: start/done handshake and operand/result bundle between controller and divider.
interface seq_restoring_div_if
   import seq_restoring_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_div_sub_stage.sv
// div_sub_stage: N-bit ripple subtractor from full-adder cells (a + ~b + 1); borrow is the difference MSB.
module div_sub_stage #(
   parameter int N = 5
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-2:0] o_diff,
   output logic         o_borrow
);
   logic [N-1:0] w_bn;
   logic [N-1:0] w_c;
   logic [N-1:0] w_s;
   assign w_bn   = ~i_b;
   assign w_c[0] = 1'b1;
   for (genvar g = 0; g < N; g++) begin : g_fa
      assign w_s[g] = i_a[g] ^ w_bn[g] ^ w_c[g];
      if (g < N - 1) begin : g_carry
         assign w_c[g+1] = (i_a[g] & w_bn[g]) | (w_c[g] & (i_a[g] ^ w_bn[g]));
      end
   end
   // The signed difference always fits N bits, so its MSB is the borrow.
   assign o_diff   = w_s[N-2:0];
   assign o_borrow = w_s[N-1];
endmodule

// File: rtl/seq_restoring_div.sv
// seq_restoring_div: unsigned sequential restoring divider, one trial subtraction per clock.
module seq_restoring_div
   import seq_restoring_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic               clk,
   input logic               rst,
   seq_restoring_div_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dbz;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_diff;
   logic             w_borrow;
   logic             w_last;
   logic             w_zero;
   logic [WIDTH-1:0] w_r_next;
   logic [WIDTH-1:0] w_q_next;
   assign w_trial  = {r_r, r_q[WIDTH-1]};
   assign w_last   = r_cnt == CW'(WIDTH - 1);
   assign w_zero   = bus.divisor == '0;
   // A kept difference is below the divisor, so the remainder MSB is always zero and is not stored.
   assign w_r_next = w_borrow ? w_trial[WIDTH-1:0] : w_diff;
   assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
   div_sub_stage #(
      .N(WIDTH + 1)
   ) u_sub (
      .i_a     (w_trial),
      .i_b     ({1'b0, r_d}),
      .o_diff  (w_diff),
      .o_borrow(w_borrow)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:    w_next = bus.start ? (w_zero ? DONE : RUN) : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_r    <= '0;
         r_q    <= '0;
         r_d    <= '0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dbz  <= 1'b0;
      end else if (r_state == IDLE && bus.start) begin
         r_d   <= bus.divisor;
         r_q   <= bus.dividend;
         r_r   <= '0;
         r_cnt <= '0;
         r_dbz <= w_zero;
         if (w_zero) begin
            r_quot <= '1;
            r_rem  <= bus.dividend;
         end
      end else if (r_state == RUN) begin
         r_r   <= w_r_next;
         r_q   <= w_q_next;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_quot <= w_q_next;
            r_rem  <= w_r_next;
         end
      end
   end
   assign bus.busy        = r_state != IDLE;
   assign bus.done        = r_state == DONE;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_restoring_div.sv
// tb_seq_restoring_div: directed and exhaustive checks of the 4-bit restoring divider.
module tb_seq_restoring_div;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   seq_restoring_div_if #(.WIDTH(4)) bus ();
   seq_restoring_div #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask
   task automatic do_div(input string tag, input int a, input int b, input int eq, input int er,
                         input int edz, input int elat);
      int lat;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 4'(a);
      bus.divisor  = 4'(b);
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = ~4'(a);
      bus.divisor  = ~4'(b);
      chk({tag, " busy"}, int'(bus.busy), 1);
      lat = 1;
      while (!bus.done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " lat"}, lat, elat);
      chk({tag, " q"}, int'(bus.quotient), eq);
      chk({tag, " r"}, int'(bus.remainder), er);
      chk({tag, " dbz"}, int'(bus.div_by_zero), edz);
      @(posedge clk);
      #1;
      chk({tag, " idle"}, int'(bus.busy) + int'(bus.done), 0);
   endtask
   initial begin
      int t, last, k;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #2;
      chk("rst busy", int'(bus.busy), 0);
      chk("rst done", int'(bus.done), 0);
      chk("rst q", int'(bus.quotient), 0);
      chk("rst r", int'(bus.remainder), 0);
      chk("rst dbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      do_div("13/3", 13, 3, 4, 1, 0, 5);
      do_div("15/1", 15, 1, 15, 0, 0, 5);
      do_div("5/7", 5, 7, 0, 5, 0, 5);
      do_div("0/9", 0, 9, 0, 0, 0, 5);
      do_div("15/15", 15, 15, 1, 0, 0, 5);
      do_div("9/0", 9, 0, 15, 9, 1, 1);
      do_div("8/2", 8, 2, 4, 0, 0, 5);
      // start raised again while running must not restart or queue a second op
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 4'd4;
      @(negedge clk);
      bus.dividend = 4'd15; bus.divisor = 4'd1;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            k++;
            chk("busy-start q", int'(bus.quotient), 1);
            chk("busy-start r", int'(bus.remainder), 2);
         end
      end
      chk("busy-start dones", k, 1);
      // asynchronous reset in the middle of a run
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst busy", int'(bus.busy), 0);
      chk("midrst q", int'(bus.quotient), 0);
      chk("midrst r", int'(bus.remainder), 0);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         k += int'(bus.done) + int'(bus.busy);
      end
      chk("midrst quiet", k, 0);
      do_div("7/2", 7, 2, 3, 1, 0, 5);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            do_div($sformatf("sw %0d/%0d", a, b), a, b, b != 0 ? a / b : 15, b != 0 ? a % b : a,
                   b == 0 ? 1 : 0, b == 0 ? 1 : 5);
      // start held high: one op every WIDTH+2 cycles
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
      t = 0; last = -1; k = 0;
      while (k < 4 && t < 60) begin
         @(posedge clk);
         #1;
         t++;
         if (bus.done) begin
            if (last >= 0) chk("b2b gap", t - last, 6);
            chk("b2b q", int'(bus.quotient), 4);
            last = t;
            k++;
         end
      end
      bus.start = 1'b0;
      chk("b2b dones", k, 4);
      @(posedge clk);
      #1;
      chk("b2b idle", int'(bus.busy), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
